// File: rtl/izh_sched_pkg.sv
// ============================================================================
//  Package  : izh_sched_pkg
//  Brief    : Shared types and default widths for izh_neuron_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package izh_sched_pkg;

    localparam int DW_DEFAULT     = 16;
    localparam int WORD_W_DEFAULT = 2 * DW_DEFAULT;
    localparam int STATE_W        = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        RDW   = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        WR    = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/izh_neuron_scheduler.sv
// ============================================================================
//  Module   : izh_neuron_scheduler
//  Brief    : Sequences one shared Izhikevich core over NUM_NEURONS neurons
//             per tick. Optional SPIKE_COUNT_EN adds a per-step spike count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module izh_neuron_scheduler
    import izh_sched_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int DW          = DW_DEFAULT,
    parameter int AW          = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [DW-1:0]          i_stim,
    output logic                   busy,
    output logic                   step_done,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic                   overrun,
`ifdef SPIKE_COUNT_EN
    output logic [$clog2(NUM_NEURONS+1)-1:0] spike_count,
`endif
    output logic [AW-1:0]          mem_addr,
    output logic                   mem_rd_en,
    input  logic [2*DW-1:0]        mem_rd_data,
    output logic                   mem_wr_en,
    output logic [2*DW-1:0]        mem_wr_data,
    output logic                   core_valid,
    input  logic                   core_ready,
    output logic [DW-1:0]          core_v,
    output logic [DW-1:0]          core_u,
    output logic [DW-1:0]          core_i,
    input  logic                   core_res_valid,
    input  logic [DW-1:0]          core_v_next,
    input  logic [DW-1:0]          core_u_next,
    input  logic                   core_spike
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AW-1:0]          r_idx;
    logic [DW-1:0]          r_stim;
    logic [DW-1:0]          r_v;
    logic [DW-1:0]          r_u;
    logic [DW-1:0]          r_v_next;
    logic [DW-1:0]          r_u_next;
    logic                   r_spike;
    logic [NUM_NEURONS-1:0] r_shadow;
    logic [NUM_NEURONS-1:0] r_spike_vec;
    logic                   r_overrun;
    logic                   w_last;

    assign w_last = (r_idx == AW'(NUM_NEURONS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_stim      <= '0;
            r_v         <= '0;
            r_u         <= '0;
            r_v_next    <= '0;
            r_u_next    <= '0;
            r_spike     <= 1'b0;
            r_shadow    <= '0;
            r_spike_vec <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // A tick that lands mid-step is dropped but remembered.
            if (tick && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (tick) begin
                        r_stim   <= i_stim;
                        r_idx    <= '0;
                        r_shadow <= '0;
                    end
                end
                RDW: begin
                    r_v <= mem_rd_data[2*DW-1:DW];
                    r_u <= mem_rd_data[DW-1:0];
                end
                WAIT: begin
                    if (core_res_valid) begin
                        r_v_next <= core_v_next;
                        r_u_next <= core_u_next;
                        r_spike  <= core_spike;
                    end
                end
                WR: begin
                    r_shadow[r_idx] <= r_spike;
                    if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_spike_vec <= r_shadow;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (tick) w_state_nxt = RD;
            RD:      w_state_nxt = RDW;
            RDW:     w_state_nxt = ISSUE;
            ISSUE:   if (core_ready) w_state_nxt = WAIT;
            WAIT:    if (core_res_valid) w_state_nxt = WR;
            WR:      w_state_nxt = w_last ? DONE : RD;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy        = (r_state != IDLE);
    assign step_done   = (r_state == DONE);
    assign mem_rd_en   = (r_state == RD);
    assign mem_wr_en   = (r_state == WR);
    assign core_valid  = (r_state == ISSUE);
    assign mem_addr    = r_idx;
    assign mem_wr_data = {r_v_next, r_u_next};
    assign core_v      = r_v;
    assign core_u      = r_u;
    assign core_i      = r_stim;
    assign spike_vec   = r_spike_vec;
    assign overrun     = r_overrun;

`ifdef SPIKE_COUNT_EN
    localparam int CNT_W = $clog2(NUM_NEURONS + 1);

    logic [CNT_W-1:0] w_pop;
    logic [CNT_W-1:0] r_spike_count;

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            w_pop = w_pop + CNT_W'(r_shadow[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spike_count <= '0;
        end else if (r_state == DONE) begin
            r_spike_count <= w_pop;
        end
    end

    assign spike_count = r_spike_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_izh_neuron_scheduler.sv
// ============================================================================
//  Module   : tb_izh_neuron_scheduler
//  Brief    : Self-checking bench with RAM/core models and a write scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_izh_neuron_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [15:0] i_stim = '0;
    logic        busy, step_done, overrun;
    logic [3:0]  spike_vec;
`ifdef SPIKE_COUNT_EN
    logic [2:0]  spike_count;
`endif
    logic [1:0]  mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_rd_data = '0;
    logic [31:0] mem_wr_data;
    logic        core_valid;
    logic        core_ready = 1'b1;
    logic [15:0] core_v, core_u, core_i;
    logic        core_res_valid;
    logic [15:0] core_v_next = '0, core_u_next = '0;
    logic        core_spike = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [4];
    logic [31:0] ref_ram [4];
    logic        load_ram = 1'b0;
    int          rd_q [$];
    logic [33:0] wr_q [$];

    logic [3:0]  spike_mask = '0;
    logic        r_res = 1'b0;
    logic        spurious_res = 1'b0;
    int          n_accept = 0;
    int          stall_target = -1;
    int          stall_left = 0;
    logic        stall_holding = 1'b0;
    logic [15:0] held_v, held_u, held_i;

    always #5 clk = ~clk;

    izh_neuron_scheduler #(.NUM_NEURONS(4), .DW(16), .AW(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .i_stim         (i_stim),
        .busy           (busy),
        .step_done      (step_done),
        .spike_vec      (spike_vec),
        .overrun        (overrun),
`ifdef SPIKE_COUNT_EN
        .spike_count    (spike_count),
`endif
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_data    (mem_rd_data),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_data    (mem_wr_data),
        .core_valid     (core_valid),
        .core_ready     (core_ready),
        .core_v         (core_v),
        .core_u         (core_u),
        .core_i         (core_i),
        .core_res_valid (core_res_valid),
        .core_v_next    (core_v_next),
        .core_u_next    (core_u_next),
        .core_spike     (core_spike)
    );

    function automatic logic [31:0] init_word(input int k);
        logic [15:0] v, u;
        v = 16'(k << 12) | 16'h0100;
        u = 16'h0200 + 16'(k);
        return {v, u};
    endfunction

    // State RAM: one-cycle read latency
    always @(posedge clk) begin
        if (load_ram) begin
            for (int k = 0; k < 4; k++) ram[k] <= init_word(k);
        end else begin
            if (mem_rd_en) mem_rd_data <= ram[mem_addr];
            if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        end
    end

    // Core model: result one cycle after accept; neuron identity in v[13:12]
    always @(posedge clk) begin
        if (rst) begin
            r_res <= 1'b0;
        end else begin
            r_res <= core_valid && core_ready;
            if (core_valid && core_ready) begin
                core_v_next <= core_v + core_i;
                core_u_next <= core_u ^ 16'h00ff;
                core_spike  <= spike_mask[core_v[13:12]];
                n_accept    <= n_accept + 1;
            end
        end
    end
    assign core_res_valid = r_res | spurious_res;

    // Back-pressure driver and operand-stability check
    always @(negedge clk) begin
        if (core_valid && stall_holding) begin
            checks++;
            if ({core_v, core_u, core_i} !== {held_v, held_u, held_i}) begin
                errors++;
                $display("FAIL operand_hold: got %h/%h/%h required %h/%h/%h",
                         core_v, core_u, core_i, held_v, held_u, held_i);
            end
        end
        if (!core_valid) stall_holding = 1'b0;
        if (core_valid && stall_left > 0 && n_accept == stall_target) begin
            if (!stall_holding) begin
                held_v = core_v; held_u = core_u; held_i = core_i;
                stall_holding = 1'b1;
            end
            core_ready = 1'b0;
            stall_left--;
        end else begin
            core_ready = 1'b1;
        end
    end

    // Scoreboard monitor for RAM traffic
    always @(negedge clk) begin
        if (!rst && mem_rd_en) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_order: unexpected read at addr %0d", mem_addr);
            end else begin
                int e;
                e = rd_q.pop_front();
                if (mem_addr !== e[1:0]) begin
                    errors++;
                    $display("FAIL rd_order: addr %0d required %0d", mem_addr, e[1:0]);
                end
            end
        end
        if (!rst && mem_wr_en) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_data: unexpected write addr %0d data %h", mem_addr, mem_wr_data);
            end else begin
                logic [33:0] e;
                e = wr_q.pop_front();
                if ({mem_addr, mem_wr_data} !== e) begin
                    errors++;
                    $display("FAIL wr_data: addr %0d data %h required addr %0d data %h",
                             mem_addr, mem_wr_data, e[33:32], e[31:0]);
                end
                ref_ram[e[33:32]] = e[31:0];
            end
        end
    end

    task automatic start_step(input logic [15:0] stim);
        for (int k = 0; k < 4; k++) begin
            logic [15:0] v, u;
            v = ref_ram[k][31:16];
            u = ref_ram[k][15:0];
            rd_q.push_back(k);
            wr_q.push_back({2'(k), v + stim, u ^ 16'h00ff});
        end
        @(negedge clk);
        tick = 1'b1;
        i_stim = stim;
        @(negedge clk);
        tick = 1'b0;
        i_stim = 16'($urandom);
    endtask

    // Cycle 1 is the negedge right after the edge that samples tick
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int n = 1; n <= 200; n++) begin
            if (step_done) begin
                cyc = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_step(input logic [15:0] stim, output int cyc);
        start_step(stim);
        wait_done(cyc);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        load_ram = 1'b1;
        for (int k = 0; k < 4; k++) ref_ram[k] = init_word(k);
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, step_done, overrun, spike_vec, mem_rd_en, mem_wr_en, core_valid} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b ovr=%b spk=%b rd=%b wr=%b cv=%b required all 0",
                     busy, step_done, overrun, spike_vec, mem_rd_en, mem_wr_en, core_valid);
        end
        load_ram = 1'b0;
        rst = 1'b0;
        spurious_res = 1'b1;
        @(negedge clk);
        spurious_res = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_res_valid: busy=%b wr=%b required 0/0", busy, mem_wr_en);
        end
    endtask

    task automatic test_basic;
        int cyc;
        spike_mask = 4'b0100;
        run_step(16'h0010, cyc);
        checks++;
        if (cyc !== 21) begin
            errors++;
            $display("FAIL basic_latency: step_done at cycle %0d required 21", cyc);
        end
        @(negedge clk);
        checks++;
        if (spike_vec !== 4'b0100 || step_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_spikes: spike_vec=%b done=%b busy=%b required 0100/0/0",
                     spike_vec, step_done, busy);
        end
        checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL basic_drain: rd_q=%0d wr_q=%0d required 0/0", rd_q.size(), wr_q.size());
        end
    endtask

    task automatic test_stall;
        int cyc;
        spike_mask   = 4'b0011;
        stall_target = n_accept + 1;
        stall_left   = 3;
        run_step(16'h0020, cyc);
        checks++;
        if (cyc !== 24) begin
            errors++;
            $display("FAIL stall_latency: step_done at cycle %0d required 24", cyc);
        end
        @(negedge clk);
        checks++;
        if (spike_vec !== 4'b0011) begin
            errors++;
            $display("FAIL stall_spikes: spike_vec=%b required 0011", spike_vec);
        end
        stall_target = -1;
    endtask

    task automatic test_overrun;
        int cyc;
        int extra;
        spike_mask = 4'b1000;
        fork
            run_step(16'h0008, cyc);
            begin
                repeat (6) @(negedge clk);
                tick = 1'b1;
                @(negedge clk);
                tick = 1'b0;
            end
        join
        checks++;
        if (cyc !== 21) begin
            errors++;
            $display("FAIL overrun_latency: step_done at cycle %0d required 21", cyc);
        end
        extra = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (step_done) extra++;
        end
        checks++;
        if (extra !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_single: extra step_done=%0d busy=%b required 0/0", extra, busy);
        end
        checks++;
        if (overrun !== 1'b1 || spike_vec !== 4'b1000) begin
            errors++;
            $display("FAIL overrun_flag: overrun=%b spike_vec=%b required 1/1000", overrun, spike_vec);
        end
    endtask

    task automatic test_reset_mid;
        int base;
        int cyc;
        bit found;
        spike_mask = 4'b1111;
        base  = n_accept;
        found = 1'b0;
        start_step(16'h0004);
        for (int n = 0; n < 100; n++) begin
            if (core_res_valid && n_accept == base + 3) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_reach: WAIT of neuron 2 not reached, got 0 required 1");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_wr_en !== 1'b0 || spike_vec !== 4'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state: busy=%b wr=%b spk=%b ovr=%b required 0/0/0000/0",
                     busy, mem_wr_en, spike_vec, overrun);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_q.size() != 2 || rd_q.size() != 1) begin
            errors++;
            $display("FAIL reset_mid_partial: wr_q=%0d rd_q=%0d required 2/1", wr_q.size(), rd_q.size());
        end
        wr_q.delete();
        rd_q.delete();
        run_step(16'h0002, cyc);
        checks++;
        if (cyc !== 21) begin
            errors++;
            $display("FAIL reset_mid_resume: step_done at cycle %0d required 21", cyc);
        end
        @(negedge clk);
        checks++;
        if (spike_vec !== 4'b1111) begin
            errors++;
            $display("FAIL reset_mid_spikes: spike_vec=%b required 1111", spike_vec);
        end
    endtask

`ifdef SPIKE_COUNT_EN
    task automatic test_spike_count;
        int cyc;
        spike_mask = 4'b1001;
        run_step(16'h0001, cyc);
        @(negedge clk);
        checks++;
        if (cyc !== 21 || spike_count !== 3'd2 || spike_vec !== 4'b1001) begin
            errors++;
            $display("FAIL spike_count_two: cyc=%0d count=%0d spk=%b required 21/2/1001",
                     cyc, spike_count, spike_vec);
        end
        spike_mask = 4'b0000;
        run_step(16'h0001, cyc);
        @(negedge clk);
        checks++;
        if (spike_count !== 3'd0 || spike_vec !== 4'b0000) begin
            errors++;
            $display("FAIL spike_count_zero: count=%0d spk=%b required 0/0000", spike_count, spike_vec);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_reset_mid();
`ifdef SPIKE_COUNT_EN
        test_spike_count();
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
